// File: rtl/bus_round_robin_scheduler.sv
// ---------------------------------------------------------------------------
// bus_round_robin_scheduler
//
// Round-robin owner sequencer for a 16-bit bus shared by three processors.
// Each processor raises req[i] and holds it until it is finished. It then
// pulses done[i], or it simply drops req[i]. The block grants ownership to
// one processor at a time. Every ownership is followed by one dead cycle.
// A hold counter forces release when an owner keeps the bus for MAX_HOLD
// cycles.
//
// Ports:
//   clock       in   1  system clock, rising edge
//   reset       in   1  asynchronous active-high reset
//   req         in   3  level request, bit i = Pi
//   done        in   3  one-cycle release pulse, only the owner's bit counts
//   grant       out  3  one-hot grant (registered)
//   proc        out  2  owner select for the bus mux, 2'b11 = no owner
//   busy        out  1  high while a grant is held
//   timeout     out  1  one-cycle pulse on a forced release
//   timeout_id  out  2  owner that timed out, held between pulses
// ---------------------------------------------------------------------------
module bus_round_robin_scheduler #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [2:0] done,
  output logic [2:0] grant,
  output logic [1:0] proc,
  output logic       busy,
  output logic       timeout,
  output logic [1:0] timeout_id
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_OWNED   = 2'b01,
    ST_RELEASE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       grant_q, grant_d;
  logic [1:0]       proc_q, proc_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       timeout_id_q, timeout_id_d;

  logic [1:0]       arb_ptr_s;
  logic [2:0]       arb_s;      // {found, index}
  logic             own_done_s;
  logic             own_req_s;

  // Round-robin pick: scan ptr+1, ptr+2, ptr+3 (mod 3), return {found, idx}.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] ptr);
    logic [2:0] res;
    res = 3'b000;
    case (ptr)
      2'd0: begin
        if (r[1])      res = {1'b1, 2'd1};
        else if (r[2]) res = {1'b1, 2'd2};
        else if (r[0]) res = {1'b1, 2'd0};
        else           res = 3'b000;
      end
      2'd1: begin
        if (r[2])      res = {1'b1, 2'd2};
        else if (r[0]) res = {1'b1, 2'd0};
        else if (r[1]) res = {1'b1, 2'd1};
        else           res = 3'b000;
      end
      default: begin
        if (r[0])      res = {1'b1, 2'd0};
        else if (r[1]) res = {1'b1, 2'd1};
        else if (r[2]) res = {1'b1, 2'd2};
        else           res = 3'b000;
      end
    endcase
    return res;
  endfunction

  // One-hot encode an owner index (index 3 maps to no grant).
  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // The release cycle arbitrates as if last_owner already held the leaving
  // owner, so a waiting requester is granted right after a single dead cycle.
  assign arb_ptr_s  = (state_q == ST_RELEASE) ? owner_q : last_q;
  assign arb_s      = rr_pick(req, arb_ptr_s);
  assign own_done_s = done[owner_q];
  assign own_req_s  = req[owner_q];

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    proc_d       = proc_q;
    busy_d       = busy_q;
    timeout_d    = 1'b0;
    timeout_id_d = timeout_id_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_s[2]) begin
          state_d = ST_OWNED;
          owner_d = arb_s[1:0];
          cnt_d   = CNT_ONE;
          grant_d = onehot3(arb_s[1:0]);
          proc_d  = arb_s[1:0];
          busy_d  = 1'b1;
        end else begin
          grant_d = 3'b000;
          proc_d  = 2'b11;
          busy_d  = 1'b0;
        end
      end

      ST_OWNED: begin
        // Priority: done, then dropped request, then hold limit.
        if (own_done_s || !own_req_s) begin
          state_d = ST_RELEASE;
          grant_d = 3'b000;
          proc_d  = 2'b11;
          busy_d  = 1'b0;
        end else if (cnt_q == MAX_HOLD_C) begin
          state_d      = ST_RELEASE;
          grant_d      = 3'b000;
          proc_d       = 2'b11;
          busy_d       = 1'b0;
          timeout_d    = 1'b1;
          timeout_id_d = owner_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_RELEASE: begin
        last_d = owner_q;
        cnt_d  = CNT_ZERO;
        if (arb_s[2]) begin
          state_d = ST_OWNED;
          owner_d = arb_s[1:0];
          cnt_d   = CNT_ONE;
          grant_d = onehot3(arb_s[1:0]);
          proc_d  = arb_s[1:0];
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          grant_d = 3'b000;
          proc_d  = 2'b11;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
        grant_d = 3'b000;
        proc_d  = 2'b11;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= 2'd0;
      last_q       <= 2'd2;
      cnt_q        <= CNT_ZERO;
      grant_q      <= 3'b000;
      proc_q       <= 2'b11;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      timeout_id_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      proc_q       <= proc_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      timeout_id_q <= timeout_id_d;
    end
  end

  assign grant      = grant_q;
  assign proc       = proc_q;
  assign busy       = busy_q;
  assign timeout    = timeout_q;
  assign timeout_id = timeout_id_q;

endmodule

// File: tb/tb_bus_round_robin_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for bus_round_robin_scheduler. It drives random request and done
// patterns and compares every output, every cycle, against a cycle-level
// reference model. The model tracks the owner, the hold count, the dead
// turnaround cycle and the rotation pointer as plain integers.
// ---------------------------------------------------------------------------
module tb_bus_round_robin_scheduler;

  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] req;
  logic [2:0] done;
  logic [2:0] grant;
  logic [1:0] proc;
  logic       busy;
  logic       timeout;
  logic [1:0] timeout_id;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // reference model state
  int m_owner;   // -1 = none
  int m_cnt;
  int m_last;
  int m_dead;
  int m_pend;
  int m_to;
  int m_toid;

  bus_round_robin_scheduler #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .proc       (proc),
    .busy       (busy),
    .timeout    (timeout),
    .timeout_id (timeout_id)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
  endtask

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_last = 2; m_dead = 0; m_pend = 0; m_to = 0; m_toid = 0;
  endtask

  task automatic model_arb(input int ptr);
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (ptr + k) % 3;
      if (req[idx]) begin
        m_owner = idx;
        m_cnt   = 1;
        break;
      end
    end
  endtask

  task automatic model_release();
    m_pend  = m_owner;
    m_owner = -1;
    m_dead  = 1;
  endtask

  // One rising edge of the scheduler, using the req/done currently applied.
  task automatic model_step();
    m_to = 0;
    if (m_owner >= 0) begin
      if (done[m_owner]) model_release();
      else if (!req[m_owner]) model_release();
      else if (m_cnt == MAX_HOLD) begin
        m_to   = 1;
        m_toid = m_owner;
        model_release();
      end else m_cnt++;
    end else if (m_dead) begin
      m_dead = 0;
      m_last = m_pend;
      m_cnt  = 0;
      model_arb(m_last);
    end else begin
      model_arb(m_last);
    end
  endtask

  task automatic check_outputs(input string phase);
    logic [2:0] eg;
    logic [1:0] ep;
    eg = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
    ep = (m_owner >= 0) ? 2'(m_owner) : 2'b11;
    check_eq({phase, ".grant"},      {5'd0, grant},       {5'd0, eg});
    check_eq({phase, ".proc"},       {6'd0, proc},        {6'd0, ep});
    check_eq({phase, ".busy"},       {7'd0, busy},        {7'd0, (m_owner >= 0)});
    check_eq({phase, ".timeout"},    {7'd0, timeout},     {7'd0, (m_to != 0)});
    check_eq({phase, ".timeout_id"}, {6'd0, timeout_id},  {6'd0, 2'(m_toid)});
  endtask

  // Advance one clock, step the model and compare 1 time unit after the edge.
  task automatic tick(input string phase);
    @(posedge clock);
    model_step();
    cyc++;
    #1;
    check_outputs(phase);
  endtask

  // Async reset pulse placed between clock edges, checked before any edge.
  task automatic async_reset_check();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_reset");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    req   = 3'b000;
    done  = 3'b000;
    model_reset();
    #1 reset = 1'b1;
    #1 check_outputs("por");
    #1 reset = 1'b0;

    // Rotation with immediate done: 00,11,01,11,10,11,00...
    req  = 3'b111;
    done = 3'b111;
    for (int i = 0; i < 24; i++) tick("rotate");

    // No done at all: every ownership ends on the hold limit.
    done = 3'b000;
    for (int i = 0; i < 40; i++) tick("hold_limit");

    // Single requester dropping its request mid-ownership.
    req = 3'b010;
    for (int i = 0; i < 3; i++) tick("abort");
    req = 3'b100;
    for (int i = 0; i < 4; i++) tick("abort");

    // Reset in the middle of an ownership, then P0 must win first.
    req = 3'b010;
    tick("mid_own");
    tick("mid_own");
    async_reset_check();
    req = 3'b111;
    tick("after_reset");
    tick("after_reset");

    // Random phase: level-held requests, sparse done pulses on any bit.
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] r;
      r = req;
      for (int b = 0; b < 3; b++) begin
        if (!r[b]) r[b] = ($urandom_range(0, 2) == 0);
        else if ($urandom_range(0, 19) == 0) r[b] = 1'b0;
      end
      req = r;
      for (int b = 0; b < 3; b++) done[b] = ($urandom_range(0, 7) == 0);
      tick("random");
      if ((i % 500) == 250) async_reset_check();
    end

    req  = 3'b000;
    done = 3'b000;
    for (int i = 0; i < 4; i++) tick("drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
